// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares an upstream free-running count against a duty threshold.
// New duty values are staged in a shadow register and applied only at a counter wrap.
module pwm_compare_stage #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned WRAP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      count,
   input  logic                  cfg_valid,
   input  logic [WIDTH-1:0]      cfg_duty,
   output logic                  cfg_ready,
   output logic                  pwm_out,
   output logic                  wrap_pulse,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
);

   logic [WIDTH-1:0]      prev_count_q, prev_count_d;
   logic                  prev_valid_q, prev_valid_d;
   logic [WIDTH-1:0]      duty_active_q, duty_active_d;
   logic [WIDTH-1:0]      duty_shadow_q, duty_shadow_d;
   logic                  pending_q, pending_d;
   logic                  pwm_q, pwm_d;
   logic                  wrap_pulse_q, wrap_pulse_d;
   logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

   logic                  wrap;
   logic                  accept;
   logic                  transfer;
   logic [WIDTH-1:0]      duty_eff;

   // A drop in count is a wrap, whether a normal rollover or an upstream restart.
   assign wrap     = prev_valid_q && (count < prev_count_q);
   assign cfg_ready = !pending_q;
   assign accept   = cfg_valid && cfg_ready;
   assign transfer = wrap && pending_q;
   assign duty_eff = transfer ? duty_shadow_q : duty_active_q;

   always_comb begin
      prev_count_d  = count;
      prev_valid_d  = 1'b1;
      duty_active_d = duty_active_q;
      duty_shadow_d = duty_shadow_q;
      pending_d     = pending_q;
      wrap_pulse_d  = wrap;
      wrap_cnt_d    = wrap_cnt_q;
      pwm_d         = (count < duty_eff);

      if (wrap) begin
         wrap_cnt_d = wrap_cnt_q + 1'b1;
      end
      // accept and transfer are mutually exclusive since they need opposite pending values
      if (accept) begin
         duty_shadow_d = cfg_duty;
         pending_d     = 1'b1;
      end else if (transfer) begin
         duty_active_d = duty_shadow_q;
         pending_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_count_q  <= '0;
         prev_valid_q  <= 1'b0;
         duty_active_q <= '0;
         duty_shadow_q <= '0;
         pending_q     <= 1'b0;
         pwm_q         <= 1'b0;
         wrap_pulse_q  <= 1'b0;
         wrap_cnt_q    <= '0;
      end else begin
         prev_count_q  <= prev_count_d;
         prev_valid_q  <= prev_valid_d;
         duty_active_q <= duty_active_d;
         duty_shadow_q <= duty_shadow_d;
         pending_q     <= pending_d;
         pwm_q         <= pwm_d;
         wrap_pulse_q  <= wrap_pulse_d;
         wrap_cnt_q    <= wrap_cnt_d;
      end
   end

   assign pwm_out    = pwm_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage: drives whole counter periods and checks
// high-time, wrap detection, config staging and asynchronous reset.
module tb_pwm_compare_stage;

   logic        clk;
   logic        reset;
   logic [7:0]  count;
   logic        cfg_valid;
   logic [7:0]  cfg_duty;
   logic        cfg_ready;
   logic        pwm_out;
   logic        wrap_pulse;
   logic [15:0] wrap_cnt;

   int total;
   int passed;

   // Per-period observations
   int   hi;
   logic wp0, wp1, rdy0, rdya, rdyb, plast;

   pwm_compare_stage #(
      .WIDTH      (8),
      .WRAP_CNT_W (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .count      (count),
      .cfg_valid  (cfg_valid),
      .cfg_duty   (cfg_duty),
      .cfg_ready  (cfg_ready),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse),
      .wrap_cnt   (wrap_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int v);
      count = v[7:0];
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   // Drive count 0..last; offer duty da at count oa and db at count ob (-1 = none).
   task automatic period(input int last, input int oa, input int da, input int ob, input int db);
      hi = 0;
      for (int v = 0; v <= last; v++) begin
         if (v == oa) begin
            cfg_valid = 1'b1;
            cfg_duty  = da[7:0];
         end else if (v == ob) begin
            cfg_valid = 1'b1;
            cfg_duty  = db[7:0];
         end
         step(v);
         if (pwm_out === 1'b1) hi++;
         if (v == 0) begin
            wp0  = wrap_pulse;
            rdy0 = cfg_ready;
         end
         if (v == 1) wp1 = wrap_pulse;
         if (v == oa) rdya = cfg_ready;
         if (v == ob) rdyb = cfg_ready;
         if (v == last) plast = pwm_out;
      end
   endtask

   initial begin
      total     = 0;
      passed    = 0;
      reset     = 1'b1;
      count     = '0;
      cfg_valid = 1'b0;
      cfg_duty  = '0;
      #2 reset = 1'b0;
      #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_wp", wrap_pulse, 0);
      chk("rst_wc", wrap_cnt, 0);
      chk("rst_ready", cfg_ready, 1);
      @(negedge clk);
      reset = 1'b1;

      // Free-running, no config
      period(255, -1, 0, -1, 0);
      chk("p1_first_wp", wp0, 0);
      chk("p1_hi", hi, 0);
      chk("p1_wc", wrap_cnt, 0);
      chk("p1_ready", cfg_ready, 1);

      // Offer 64 mid-period
      period(255, 100, 64, -1, 0);
      chk("p2_wp0", wp0, 1);
      chk("p2_wp1", wp1, 0);
      chk("p2_hi", hi, 0);
      chk("p2_ready_after_accept", rdya, 0);
      chk("p2_wc", wrap_cnt, 1);

      period(255, -1, 0, -1, 0);
      chk("p3_hi64", hi, 64);
      chk("p3_ready_after_wrap", rdy0, 1);
      chk("p3_last_low", plast, 0);
      chk("p3_wc", wrap_cnt, 2);

      // Stage 200, then a held-off offer of 10
      period(255, 5, 200, 100, 10);
      chk("p4_hi64", hi, 64);
      chk("p4_ready_a", rdya, 0);
      chk("p4_ready_b", rdyb, 0);
      chk("p4_wc", wrap_cnt, 3);

      // 200 takes effect; re-offer 10 right after the wrap
      period(255, 1, 10, -1, 0);
      chk("p5_hi200", hi, 200);
      chk("p5_ready0", rdy0, 1);
      chk("p5_ready_a", rdya, 0);
      chk("p5_wc", wrap_cnt, 4);

      period(255, 3, 0, -1, 0);
      chk("p6_hi10", hi, 10);
      chk("p6_wc", wrap_cnt, 5);

      period(255, 3, 255, -1, 0);
      chk("p7_hi0", hi, 0);

      period(255, -1, 0, -1, 0);
      chk("p8_hi255", hi, 255);
      chk("p8_last_low", plast, 0);
      chk("p8_wc", wrap_cnt, 7);

      // Upstream counter restarts at 130
      period(130, 3, 100, -1, 0);
      chk("p9_hi131", hi, 131);
      chk("p9_last_high", plast, 1);
      chk("p9_wc", wrap_cnt, 8);

      period(255, -1, 0, -1, 0);
      chk("p10_wp0", wp0, 1);
      chk("p10_hi100", hi, 100);
      chk("p10_wc", wrap_cnt, 9);

      // Reset mid-period with config pending and pwm high
      period(50, 3, 50, -1, 0);
      chk("p11_hi51", hi, 51);
      chk("p11_pwm_high", pwm_out, 1);
      chk("p11_pending", cfg_ready, 0);
      #2 reset = 1'b0;
      #1;
      chk("arst_pwm", pwm_out, 0);
      chk("arst_ready", cfg_ready, 1);
      chk("arst_wc", wrap_cnt, 0);
      chk("arst_wp", wrap_pulse, 0);
      @(negedge clk);
      reset = 1'b1;

      period(255, -1, 0, -1, 0);
      chk("p12_first_wp", wp0, 0);
      chk("p12_hi0", hi, 0);
      chk("p12_wc", wrap_cnt, 0);

      period(255, -1, 0, -1, 0);
      chk("p13_wp0", wp0, 1);
      chk("p13_hi0_discarded", hi, 0);
      chk("p13_wc", wrap_cnt, 1);

      // Count held constant is not a wrap
      step(255);
      chk("hold_wp", wrap_pulse, 0);
      chk("hold_wc", wrap_cnt, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
Downstream consumer of the free-running 8-bit counter. Compares the counter value `count` against a duty threshold and produces a glitch-free registered PWM output. New thresholds arrive through a valid/ready config handshake. They are staged in a shadow register and only take effect at a counter wrap, so a period is never corrupted mid-way. The block also emits a one-cycle wrap pulse and keeps a running count of completed periods.

Parameters:
WIDTH, 8, width of the counter input and the duty threshold
WRAP_CNT_W, 16, width of the completed-period counter

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
count  input  WIDTH  counter value from upstream counter, sampled every clk
cfg_valid  input  1  new duty value offered
cfg_duty  input  WIDTH  duty threshold, in counts per period
cfg_ready  output  1  block can accept a duty value; equals !pending
pwm_out  output  1  registered PWM output
wrap_pulse  output  1  one-cycle pulse, registered, after a wrap is detected
wrap_cnt  output  WRAP_CNT_W  number of wraps since reset

Behaviour:
- Reset (reset==0, async): all registers clear.
  - pwm_out=0, wrap_pulse=0, wrap_cnt=0.
  - duty_active=0, duty_shadow=0, pending=0 (so cfg_ready=1).
  - prev_count=0, prev_valid=0.
- prev_count/prev_valid:
  - Each clk, prev_count<=count.
  - prev_valid<=1 on the first clk after reset release.
- Wrap detect (combinational): wrap = prev_valid && (count < prev_count).
  - The normal MAX->0 rollover is a wrap.
  - An upstream reset mid-period (count drops to 0) is also a wrap.
  - count held constant is not a wrap.
  - No wrap is possible on the first cycle after reset.
- Config handshake:
  - Accept when cfg_valid && cfg_ready: duty_shadow<=cfg_duty, pending<=1.
  - cfg_valid while !cfg_ready is held off; cfg_duty is ignored and no state changes.
  - cfg_ready is combinational from the pending register only, with no path from cfg_valid.
- Shadow transfer, on wrap && pending: duty_active<=duty_shadow, pending<=0.
- Same-cycle accept and wrap: impossible by construction, because an accept needs pending=0 and a transfer needs pending=1.
  - The newly accepted value applies at the next wrap, not the current one.
- Effective duty (combinational): duty_eff = (wrap && pending) ? duty_shadow : duty_active.
- pwm_out:
  - Update: pwm_out <= (count < duty_eff); one clk latency from count.
  - duty=0: constantly low.
  - duty=2^WIDTH-1: high except at count=MAX.
  - Unsigned WIDTH-bit compare; no extension beyond WIDTH.
- wrap_pulse <= wrap, so it is high for exactly one clk per wrap.
- wrap_cnt:
  - Increments by 1 on each wrap.
  - Rolls over from 2^WRAP_CNT_W-1 to 0; it does not saturate.
- Reset asserted mid-period:
  - Pending config is discarded.
  - Output drops to 0 immediately, asynchronously.
  - After release, the first wrap is detected only once prev_valid=1.

Test Plan:
1. Release reset, upstream counter free-running 0..255, no config -> pwm_out=0 throughout; wrap_pulse high 1 clk after each count 255->0; wrap_cnt 1, 2, 3, ... ; cfg_ready=1.
2. Offer cfg_duty=64 mid-period at count=100 -> cfg_ready drops the next clk; pwm_out stays 0 until the wrap. From the cycle after count=0, pwm_out is high for counts 0..63 (64 clks) and low for 64..255. cfg_ready returns to 1 the clk after the wrap.
3. With pending=1 (duty=200 staged), offer cfg_duty=10 -> cfg_ready=0, offer ignored. After the wrap duty_active=200; a re-offer of 10 is accepted and applies from the following wrap.
4. Duty boundaries: duty=0 -> pwm_out 0 for a full period. duty=255 -> pwm_out high for 255 clks and low only when count=255.
5. Upstream counter reset pulsed at count=130 (count forced to 0) -> treated as a wrap: wrap_pulse asserted, wrap_cnt increments, a staged duty transfers.
6. Assert reset at count=50 with pending=1 and pwm_out=1 -> pwm_out=0, cfg_ready=1 and wrap_cnt=0 immediately, without waiting for a clk edge. After release, no wrap_pulse occurs on the first cycle, and duty_active=0.
